// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: router mode codes, memory
// access kinds, FSM states and the kind-to-mode mapping.
package tau_pkg;

    localparam int MODE_INSTR  = 0;
    localparam int MODE_PEEK   = 1;
    localparam int MODE_LOAD_P = 2;
    localparam int MODE_LOAD_V = 3;

    typedef enum logic [1:0] {
        KIND_PEEK   = 2'd0,
        KIND_LOAD_P = 2'd1,
        KIND_LOAD_V = 2'd2,
        KIND_RSVD   = 2'd3
    } mem_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_ADDR,
        ST_FETCH_CAP,
        ST_DISPATCH,
        ST_MEM_ADDR,
        ST_MEM_CAP
    } state_e;

    // Router select for a requested access; the reserved kind behaves as a peek.
    function automatic int kind_to_mode(input mem_kind_e kind);
        case (kind)
            KIND_LOAD_P: return MODE_LOAD_P;
            KIND_LOAD_V: return MODE_LOAD_V;
            default:     return MODE_PEEK;
        endcase
    endfunction

    // Only variable-RAM loads read the variable RAM; everything else reads program RAM.
    function automatic logic kind_uses_vram(input mem_kind_e kind);
        return kind == KIND_LOAD_V;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake between the fetch sequencer (master) and the execute stage (slave):
// instruction presentation with valid/ack, plus jump and memory-access requests
// that ride on the ack.
interface fetch_sequencer_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
) ();
    logic [WORD_SIZE-1:0] ir;
    logic                 ir_valid;
    logic                 ir_ack;
    logic                 mem_req;
    logic [1:0]           mem_kind;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 jump_en;
    logic [ADDR_SIZE-1:0] jump_addr;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_valid;

    modport master (
        output ir, ir_valid, mem_data, mem_valid,
        input  ir_ack, mem_req, mem_kind, mem_addr, jump_en, jump_addr
    );

    modport slave (
        input  ir, ir_valid, mem_data, mem_valid,
        output ir_ack, mem_req, mem_kind, mem_addr, jump_en, jump_addr
    );
endinterface

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: holds pc, increments with natural wrap at 2^ADDR_SIZE,
// or loads a jump target. Load wins if both are requested.
module pc_counter #(
    parameter int          ADDR_SIZE = 8,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    input  logic                 i_load,
    input  logic [ADDR_SIZE-1:0] i_load_val,
    output logic [ADDR_SIZE-1:0] o_pc
);
    logic [ADDR_SIZE-1:0] r_pc;

    // pc register: synchronous reset, then jump load, then increment.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_pc <= ADDR_SIZE'(RESET_PC);
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_SIZE'(1);
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives program/variable RAM reads and the router mode,
// captures routed words, and presents one instruction at a time to the
// execute stage. Peek/load accesses are serviced between instructions.
module fetch_sequencer
    import tau_pkg::*;
#(
    parameter int          WORD_SIZE        = 16,
    parameter int          ADDR_SIZE        = 8,
    parameter int          MODE_SELECT_SIZE = 3,
    parameter int unsigned RESET_PC         = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic [WORD_SIZE-1:0]        instruction,
    input  logic [WORD_SIZE-1:0]        peek,
    input  logic [WORD_SIZE-1:0]        load,
    output logic [ADDR_SIZE-1:0]        p_ram_addr,
    output logic                        p_ram_re,
    output logic [ADDR_SIZE-1:0]        v_ram_addr,
    output logic                        v_ram_re,
    output logic [MODE_SELECT_SIZE-1:0] mode,
    output logic [ADDR_SIZE-1:0]        pc,
    output logic                        busy,
    fetch_sequencer_if.master           exe
);
    state_e                      r_state;
    logic [WORD_SIZE-1:0]        r_ir;
    logic                        r_ir_valid;
    logic [WORD_SIZE-1:0]        r_mem_data;
    logic                        r_mem_valid;
    logic [ADDR_SIZE-1:0]        r_p_ram_addr;
    logic                        r_p_ram_re;
    logic [ADDR_SIZE-1:0]        r_v_ram_addr;
    logic                        r_v_ram_re;
    logic [MODE_SELECT_SIZE-1:0] r_mode;

    logic                        w_ack;
    logic                        w_pc_inc;
    logic                        w_pc_load;
    logic [ADDR_SIZE-1:0]        w_pc;
    logic [ADDR_SIZE-1:0]        w_next_fetch_addr;
    mem_kind_e                   w_kind;

    // ir_valid is always set while in DISPATCH, so an ack elsewhere is ignored.
    assign w_ack     = (r_state == ST_DISPATCH) && exe.ir_ack;
    assign w_pc_inc  = (r_state == ST_FETCH_CAP);
    assign w_pc_load = w_ack && exe.jump_en;
    assign w_kind    = mem_kind_e'(exe.mem_kind);

    // A fetch started on the same edge as a jump must already use the target.
    assign w_next_fetch_addr = w_pc_load ? exe.jump_addr : w_pc;

    pc_counter #(
        .ADDR_SIZE (ADDR_SIZE),
        .RESET_PC  (RESET_PC)
    ) u_pc_counter (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_pc_inc),
        .i_load     (w_pc_load),
        .i_load_val (exe.jump_addr),
        .o_pc       (w_pc)
    );

    // Sequencer FSM with registered read enables, addresses, mode and captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ir         <= '0;
            r_ir_valid   <= 1'b0;
            r_mem_data   <= '0;
            r_mem_valid  <= 1'b0;
            r_p_ram_addr <= '0;
            r_p_ram_re   <= 1'b0;
            r_v_ram_addr <= '0;
            r_v_ram_re   <= 1'b0;
            r_mode       <= MODE_SELECT_SIZE'(MODE_INSTR);
        end else begin
            // NOTE: single-cycle strobes default low here so only the state
            // that wants them raises them for exactly one cycle.
            r_mem_valid <= 1'b0;
            r_p_ram_re  <= 1'b0;
            r_v_ram_re  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_p_ram_addr <= w_pc;
                        r_p_ram_re   <= 1'b1;
                        r_state      <= ST_FETCH_ADDR;
                    end
                end

                ST_FETCH_ADDR: begin
                    r_state <= ST_FETCH_CAP;
                end

                ST_FETCH_CAP: begin
                    r_ir       <= instruction;
                    r_ir_valid <= 1'b1;
                    r_state    <= ST_DISPATCH;
                end

                ST_DISPATCH: begin
                    if (w_ack) begin
                        r_ir_valid <= 1'b0;
                        if (exe.mem_req) begin
                            r_mode <= MODE_SELECT_SIZE'(kind_to_mode(w_kind));
                            if (kind_uses_vram(w_kind)) begin
                                r_v_ram_addr <= exe.mem_addr;
                                r_v_ram_re   <= 1'b1;
                            end else begin
                                r_p_ram_addr <= exe.mem_addr;
                                r_p_ram_re   <= 1'b1;
                            end
                            r_state <= ST_MEM_ADDR;
                        end else if (run) begin
                            r_p_ram_addr <= w_next_fetch_addr;
                            r_p_ram_re   <= 1'b1;
                            r_state      <= ST_FETCH_ADDR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_MEM_ADDR: begin
                    r_state <= ST_MEM_CAP;
                end

                ST_MEM_CAP: begin
                    r_mem_data  <= (r_mode == MODE_SELECT_SIZE'(MODE_PEEK)) ? peek : load;
                    r_mem_valid <= 1'b1;
                    r_mode      <= MODE_SELECT_SIZE'(MODE_INSTR);
                    if (run) begin
                        r_p_ram_addr <= w_pc;
                        r_p_ram_re   <= 1'b1;
                        r_state      <= ST_FETCH_ADDR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign p_ram_addr    = r_p_ram_addr;
    assign p_ram_re      = r_p_ram_re;
    assign v_ram_addr    = r_v_ram_addr;
    assign v_ram_re      = r_v_ram_re;
    assign mode          = r_mode;
    assign pc            = w_pc;
    assign busy          = (r_state != ST_IDLE);
    assign exe.ir        = r_ir;
    assign exe.ir_valid  = r_ir_valid;
    assign exe.mem_data  = r_mem_data;
    assign exe.mem_valid = r_mem_valid;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: synchronous RAMs and a combinational
// router around the DUT, a latency-based behavioural model, a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_fetch_sequencer;
    localparam int WS = 16;
    localparam int AS = 8;
    localparam int MS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [WS-1:0] instruction;
    logic [WS-1:0] peek;
    logic [WS-1:0] load;
    logic [AS-1:0] p_ram_addr;
    logic          p_ram_re;
    logic [AS-1:0] v_ram_addr;
    logic          v_ram_re;
    logic [MS-1:0] mode;
    logic [AS-1:0] pc;
    logic          busy;

    fetch_sequencer_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) exe ();

    fetch_sequencer #(
        .WORD_SIZE        (WS),
        .ADDR_SIZE        (AS),
        .MODE_SELECT_SIZE (MS),
        .RESET_PC         (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instruction (instruction),
        .peek        (peek),
        .load        (load),
        .p_ram_addr  (p_ram_addr),
        .p_ram_re    (p_ram_re),
        .v_ram_addr  (v_ram_addr),
        .v_ram_re    (v_ram_re),
        .mode        (mode),
        .pc          (pc),
        .busy        (busy),
        .exe         (exe)
    );

    always #5 clk = ~clk;

    // ---------------- environment: synchronous RAMs + router ----------------
    logic [WS-1:0] p_ram [256];
    logic [WS-1:0] v_ram [256];
    logic [WS-1:0] p_rdata = '0;
    logic [WS-1:0] v_rdata = '0;

    always @(posedge clk) begin
        if (p_ram_re) p_rdata <= p_ram[p_ram_addr];
        if (v_ram_re) v_rdata <= v_ram[v_ram_addr];
    end

    // Unselected router outputs carry junk so a wrong mode corrupts the capture.
    always_comb begin
        instruction = (mode == 3'd0) ? p_rdata : 16'hDEAD;
        peek        = (mode == 3'd1) ? p_rdata : 16'hBEEF;
        load        = (mode == 3'd2) ? p_rdata : (mode == 3'd3) ? v_rdata : 16'hCAFE;
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Rules: a fetch started at edge n yields ir at edge n+2 (pc then advances);
    // an accepted ack with a request yields mem_data at edge n+2 and holds the
    // access mode for those two cycles; each completion starts a fetch if run,
    // otherwise the sequencer goes idle.
    int            n = 0;
    int            t_ir = -1;
    int            t_mem = -1;
    bit            m_idle = 1'b1;
    logic [AS-1:0] m_pc = '0;
    logic [WS-1:0] m_ir = '0;
    bit            m_ir_valid = 1'b0;
    logic [WS-1:0] m_mem_data = '0;
    bit            m_mem_valid = 1'b0;
    logic [WS-1:0] m_pend_data = '0;
    int            m_pend_mode = 0;
    int            m_mode = 0;
    bit            m_p_re = 1'b0;
    bit            m_v_re = 1'b0;
    logic [AS-1:0] m_p_addr = '0;
    logic [AS-1:0] m_v_addr = '0;

    task automatic sched_fetch();
        t_ir     = n + 2;
        m_p_re   = 1'b1;
        m_p_addr = m_pc;
        m_idle   = 1'b0;
    endtask

    initial forever begin
        bit start;
        bit ack_taken;
        bit mem_done;
        bit fetch_done;
        @(posedge clk);
        n++;
        if (rst) begin
            t_ir = -1; t_mem = -1; m_idle = 1'b1; m_pc = '0; m_ir = '0;
            m_ir_valid = 1'b0; m_mem_data = '0; m_mem_valid = 1'b0;
            m_p_re = 1'b0; m_v_re = 1'b0; m_p_addr = '0; m_v_addr = '0;
        end else begin
            start      = m_idle && run;
            ack_taken  = m_ir_valid && exe.ir_ack;
            mem_done   = (t_mem == n);
            fetch_done = (t_ir == n);
            m_p_re = 1'b0;
            m_v_re = 1'b0;
            m_mem_valid = 1'b0;
            if (fetch_done) begin
                m_ir       = p_ram[m_pc];
                m_ir_valid = 1'b1;
                m_pc       = m_pc + 8'd1;
                t_ir       = -1;
            end
            if (start) sched_fetch();
            if (ack_taken) begin
                m_ir_valid = 1'b0;
                if (exe.jump_en) m_pc = exe.jump_addr;
                if (exe.mem_req) begin
                    t_mem = n + 2;
                    if (exe.mem_kind == 2'd2) begin
                        m_v_re = 1'b1; m_v_addr = exe.mem_addr;
                        m_pend_data = v_ram[exe.mem_addr]; m_pend_mode = 3;
                    end else begin
                        m_p_re = 1'b1; m_p_addr = exe.mem_addr;
                        m_pend_data = p_ram[exe.mem_addr];
                        m_pend_mode = (exe.mem_kind == 2'd1) ? 2 : 1;
                    end
                end else if (run) begin
                    sched_fetch();
                end else begin
                    m_idle = 1'b1;
                end
            end
            if (mem_done) begin
                m_mem_valid = 1'b1;
                m_mem_data  = m_pend_data;
                t_mem       = -1;
                if (run) sched_fetch();
                else     m_idle = 1'b1;
            end
        end
        m_mode = (t_mem >= 0) ? m_pend_mode : 0;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ir_valid",  32'(exe.ir_valid),  32'(m_ir_valid));
            check("ir",        32'(exe.ir),        32'(m_ir));
            check("mem_valid", 32'(exe.mem_valid), 32'(m_mem_valid));
            check("mem_data",  32'(exe.mem_data),  32'(m_mem_data));
            check("pc",        32'(pc),            32'(m_pc));
            check("busy",      32'(busy),          32'(!m_idle));
            check("mode",      32'(mode),          32'(m_mode));
            check("p_ram_re",  32'(p_ram_re),      32'(m_p_re));
            check("v_ram_re",  32'(v_ram_re),      32'(m_v_re));
            if (m_p_re) check("p_ram_addr", 32'(p_ram_addr), 32'(m_p_addr));
            if (m_v_re) check("v_ram_addr", 32'(v_ram_addr), 32'(m_v_addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_ack(input bit req, input logic [1:0] kind, input logic [7:0] addr,
                          input bit jmp, input logic [7:0] jaddr);
        exe.ir_ack    = 1'b1;
        exe.mem_req   = req;
        exe.mem_kind  = kind;
        exe.mem_addr  = addr;
        exe.jump_en   = jmp;
        exe.jump_addr = jaddr;
        @(negedge clk);
        exe.ir_ack  = 1'b0;
        exe.mem_req = 1'b0;
        exe.jump_en = 1'b0;
    endtask

    task automatic wait_ir_valid(input int max_cycles);
        int k = 0;
        while (exe.ir_valid !== 1'b1 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (exe.ir_valid !== 1'b1) begin
            bad++;
            $display("FAIL wait_ir_valid: ir_valid still low after %0d cycles", max_cycles);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            p_ram[i] = 16'($urandom);
            v_ram[i] = 16'($urandom);
        end
        p_ram[8'h00] = 16'h1234;
        p_ram[8'h01] = 16'hABCD;
        p_ram[8'h02] = 16'h2222;
        p_ram[8'h05] = 16'h5555;
        p_ram[8'h40] = 16'h4040;
        p_ram[8'hFF] = 16'hF0F0;
        v_ram[8'h10] = 16'h00FF;

        rst = 1'b1; run = 1'b0;
        exe.ir_ack = 1'b0; exe.mem_req = 1'b0; exe.mem_kind = 2'd0;
        exe.mem_addr = '0; exe.jump_en = 1'b0; exe.jump_addr = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        // Reset state.
        check("rst_ir",       32'(exe.ir),        32'h0);
        check("rst_ir_valid", 32'(exe.ir_valid),  32'h0);
        check("rst_pc",       32'(pc),            32'h0);
        check("rst_busy",     32'(busy),          32'h0);
        check("rst_mode",     32'(mode),          32'h0);
        check("rst_p_re",     32'(p_ram_re),      32'h0);
        check("rst_mem_data", 32'(exe.mem_data),  32'h0);

        // First fetch: ir valid exactly three edges after reset release.
        rst = 1'b0; run = 1'b1;
        repeat (2) @(negedge clk);
        check("fetch0_not_early", 32'(exe.ir_valid), 32'h0);
        @(negedge clk);
        check("fetch0_valid", 32'(exe.ir_valid), 32'h1);
        check("fetch0_ir",    32'(exe.ir),       32'h1234);
        check("fetch0_pc",    32'(pc),           32'h01);

        // Plain ack; ir holds while unacked.
        do_ack(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        wait_ir_valid(20);
        check("fetch1_ir", 32'(exe.ir), 32'hABCD);
        check("fetch1_pc", 32'(pc),     32'h02);
        repeat (5) @(negedge clk);
        check("hold_ir",    32'(exe.ir),       32'hABCD);
        check("hold_valid", 32'(exe.ir_valid), 32'h1);

        // Variable-RAM load.
        do_ack(1'b1, 2'd2, 8'h10, 1'b0, 8'h00);
        check("ldv_mode_addr", 32'(mode),       32'h3);
        check("ldv_v_re",      32'(v_ram_re),   32'h1);
        check("ldv_v_addr",    32'(v_ram_addr), 32'h10);
        check("ldv_p_re",      32'(p_ram_re),   32'h0);
        @(negedge clk);
        check("ldv_mode_cap",  32'(mode),       32'h3);
        @(negedge clk);
        check("ldv_mem_valid", 32'(exe.mem_valid), 32'h1);
        check("ldv_mem_data",  32'(exe.mem_data),  32'h00FF);
        check("ldv_pc",        32'(pc),            32'h02);
        @(negedge clk);
        check("ldv_pulse_end", 32'(exe.mem_valid), 32'h0);
        wait_ir_valid(20);
        check("fetch2_ir", 32'(exe.ir), 32'h2222);
        check("fetch2_pc", 32'(pc),     32'h03);

        // Jump plus peek in the same ack.
        do_ack(1'b1, 2'd0, 8'h05, 1'b1, 8'h40);
        check("pk_mode",   32'(mode),       32'h1);
        check("pk_p_re",   32'(p_ram_re),   32'h1);
        check("pk_p_addr", 32'(p_ram_addr), 32'h05);
        repeat (2) @(negedge clk);
        check("pk_mem_data",  32'(exe.mem_data), 32'h5555);
        check("pk_pc",        32'(pc),           32'h40);
        check("pk_next_addr", 32'(p_ram_addr),   32'h40);
        wait_ir_valid(20);
        check("fetch40_ir", 32'(exe.ir), 32'h4040);
        check("fetch40_pc", 32'(pc),     32'h41);

        // pc wrap from 0xFF.
        do_ack(1'b0, 2'd0, 8'h00, 1'b1, 8'hFF);
        wait_ir_valid(20);
        check("wrap_ir", 32'(exe.ir), 32'hF0F0);
        check("wrap_pc", 32'(pc),     32'h00);
        do_ack(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        check("wrap_fetch_addr", 32'(p_ram_addr), 32'h00);
        wait_ir_valid(20);
        check("wrap_next_ir", 32'(exe.ir), 32'h1234);

        // Reset during MEM_CAP abandons the access.
        do_ack(1'b1, 2'd1, 8'h03, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_ir_valid",  32'(exe.ir_valid),  32'h0);
        check("mrst_mem_valid", 32'(exe.mem_valid), 32'h0);
        check("mrst_pc",        32'(pc),            32'h0);
        check("mrst_busy",      32'(busy),          32'h0);
        rst = 1'b0; run = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // run dropped mid-fetch: fetch and dispatch complete, then idle.
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_ir_valid(20);
        check("stop_ir",   32'(exe.ir), 32'h1234);
        check("stop_busy", 32'(busy),   32'h1);
        repeat (2) @(negedge clk);
        do_ack(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        check("stop_idle",  32'(busy), 32'h0);
        check("stop_pc",    32'(pc),   32'h01);
        check("stop_ir_kept", 32'(exe.ir), 32'h1234);

        // Random traffic checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            run           = ($urandom_range(0, 9) != 0);
            rst           = ($urandom_range(0, 399) == 0);
            exe.ir_ack    = ($urandom_range(0, 2) == 0);
            exe.mem_req   = ($urandom_range(0, 2) == 0);
            exe.mem_kind  = 2'($urandom_range(0, 3));
            exe.mem_addr  = 8'($urandom);
            exe.jump_en   = ($urandom_range(0, 4) == 0);
            exe.jump_addr = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; run = 1'b0; exe.ir_ack = 1'b0; exe.mem_req = 1'b0; exe.jump_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control stage directly upstream of the datapath router. It drives the program-RAM and variable-RAM read ports and the router's mode select.
- It captures the routed instruction, peek or load word into registers.
- It owns the program counter and presents one instruction at a time to the execute stage with a valid/ack handshake. Peek and load accesses are serviced between instructions.

Parameters:
- WORD_SIZE, 16, data/instruction word width
- ADDR_SIZE, 8, program-RAM and variable-RAM address width
- MODE_SELECT_SIZE, 3, router mode select width
- RESET_PC, 0, program counter value after reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  enables instruction fetching
- instruction  in  WORD_SIZE  router instruction output (valid when mode=0)
- peek  in  WORD_SIZE  router peek output (valid when mode=1)
- load  in  WORD_SIZE  router load output (valid when mode=2 or 3)
- p_ram_addr  out  ADDR_SIZE  program-RAM read address
- p_ram_re  out  1  program-RAM read enable
- v_ram_addr  out  ADDR_SIZE  variable-RAM read address
- v_ram_re  out  1  variable-RAM read enable
- mode  out  MODE_SELECT_SIZE  router select: 0 instruction, 1 peek, 2 load program RAM, 3 load variable RAM
- ir  out  WORD_SIZE  instruction register
- ir_valid  out  1  ir holds an instruction not yet acked
- ir_ack  in  1  execute stage consumes ir
- mem_req  in  1  with ir_ack: request a peek/load after this instruction
- mem_kind  in  2  0 peek, 1 load program RAM, 2 load variable RAM, 3 reserved (treated as 0)
- mem_addr  in  ADDR_SIZE  address for the requested access
- jump_en  in  1  with ir_ack: load pc from jump_addr
- jump_addr  in  ADDR_SIZE  jump target
- mem_data  out  WORD_SIZE  captured peek/load word
- mem_valid  out  1  one-cycle pulse, mem_data updated
- pc  out  ADDR_SIZE  program counter
- busy  out  1  state != IDLE

Behaviour:
- Program and variable RAMs are synchronous: data appears the cycle after the address/re cycle.
- The router is combinational, so mode is held stable through each capture cycle.
- Reset values:
  - state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, mem_data=0, mem_valid=0
  - p_ram_re=0, v_ram_re=0, mode=0, both addresses=0
- FSM states: IDLE, FETCH_ADDR, FETCH_CAP, DISPATCH, MEM_ADDR, MEM_CAP.
- IDLE: mode=0, no reads. Goes to FETCH_ADDR when run=1.
- FETCH_ADDR: p_ram_addr=pc, p_ram_re=1, mode=0. Goes to FETCH_CAP.
- FETCH_CAP: mode=0. Registers ir<=instruction and ir_valid<=1, increments pc modulo 2^ADDR_SIZE (wraps 0xFF->0x00 at the default width). Goes to DISPATCH.
- Fetch latency: ir_valid rises 2 cycles after entering FETCH_ADDR.
- DISPATCH: holds ir and ir_valid until ir_ack=1. On ack:
  - ir_valid<=0.
  - If jump_en: pc<=jump_addr.
  - If mem_req: latch kind and address, go to MEM_ADDR.
  - Else if run: go to FETCH_ADDR.
  - Else: go to IDLE.
- mem_req and jump_en together: the jump applies to pc and the memory access still runs; the next fetch is from jump_addr.
- MEM_ADDR: mode is set to the latched kind mapping (kind0->1, kind1->2, kind2->3, kind3->1).
  - Program-RAM kinds drive p_ram_addr and p_ram_re; variable-RAM kinds drive v_ram_addr and v_ram_re.
  - Goes to MEM_CAP.
- MEM_CAP: same mode. mem_data<=peek when mode=1, else load. mem_valid pulses 1 in the following cycle. pc is unchanged. Goes to FETCH_ADDR if run, else IDLE.
- ir_ack while ir_valid=0 is ignored. mem_req and jump_en without ir_ack are ignored.
- run deasserted mid-fetch or mid-access: the current sequence completes, including DISPATCH, then the FSM goes to IDLE. pc and ir are retained.
- rst at any cycle: all state returns to reset values on that edge. An outstanding access is abandoned.
- Read enables are high only in FETCH_ADDR and MEM_ADDR.

Decomposition:
- Package tau_pkg holds:
  - mode constants MODE_INSTR=0, MODE_PEEK=1, MODE_LOAD_P=2, MODE_LOAD_V=3
  - mem_kind enum
  - FSM state enum
- One sub-module, pc_counter: increment/load with wrap, holding pc.

Test Plan:
- Reset then run=1, p_ram[0]=0x1234 -> ir=0x1234, ir_valid=1 exactly 3 cycles after reset release; pc=1.
- Ack with no request, p_ram[1]=0xABCD -> next ir=0xABCD, pc=2; ir holds value while ir_ack=0 for 5 cycles.
- Ack with mem_req, kind=2, addr=0x10, v_ram[0x10]=0x00FF -> mode=3 in MEM_ADDR/MEM_CAP, v_ram_re pulse; mem_data=0x00FF with one mem_valid pulse; pc unchanged; fetch resumes.
- Ack with jump_en, jump_addr=0x40, plus mem_req kind=0, addr=0x05, p_ram[0x05]=0x5555 -> mem_data=0x5555 via mode=1, then fetch at p_ram_addr=0x40.
- pc=0xFF, fetch -> pc wraps to 0x00; next fetch address 0x00.
- rst asserted in MEM_CAP -> next cycle IDLE, ir_valid=0, mem_valid=0, pc=RESET_PC; run=0 mid-fetch -> completes DISPATCH, then IDLE with busy=0.
